// File: rtl/light_encryptor.sv
// light_encryptor: encrypts a record as NUM_BLOCKS keystream-XORed 128-bit blocks and tags it.
// Optional: define LIGHT_ENC_SEQ_IN_TAG_EN to fold the sequence number into the final tag.
module light_encryptor #(
    parameter logic [127:0] KEY        = 128'h0123456789abcdeffedcba9876543210,
    parameter logic [127:0] MAC_KEY    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
    parameter int unsigned  NUM_BLOCKS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_BLOCKS*128-1:0] req_plaintext,
    input  logic                      req_val,
    output logic                      req_rdy,
    output logic [NUM_BLOCKS*128-1:0] resp_ciphertext,
    output logic [127:0]              resp_hmac,
    output logic                      resp_val,
    input  logic                      resp_rdy,
    output logic [31:0]               resp_seq
);

    localparam int unsigned RW = NUM_BLOCKS * 128;
    localparam int unsigned BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [BW-1:0] LAST = BW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENC,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   seq_q, seq_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [RW-1:0] work_q, work_d;
    logic [127:0]  tag_q, tag_d;
    logic [RW-1:0] ct_q, ct_d;
    logic [127:0]  hmac_q, hmac_d;

    logic [127:0]  pt_blk;
    logic [127:0]  ks;
    logic [127:0]  ct_blk;
    logic [127:0]  tag_nx;
    logic [RW-1:0] work_nx;
    logic [127:0]  seq_bind;

`ifdef LIGHT_ENC_SEQ_IN_TAG_EN
    assign seq_bind = {96'h0, seq_q};
`else
    assign seq_bind = '0;
`endif

    // Datapath for the block currently selected by blk_q, written back in place.
    always_comb begin
        pt_blk  = '0;
        work_nx = work_q;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (blk_q == BW'(i)) begin
                pt_blk = work_q[i*128 +: 128];
            end
        end
        ks     = KEY ^ {seq_q, 32'(blk_q), 64'h0};
        ct_blk = pt_blk ^ ks;
        tag_nx = {tag_q[126:0], tag_q[127]} ^ ct_blk;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (blk_q == BW'(i)) begin
                work_nx[i*128 +: 128] = ct_blk;
            end
        end
    end

    // Next-state logic for the accept / encrypt / respond sequence.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        blk_d   = blk_q;
        work_d  = work_q;
        tag_d   = tag_q;
        ct_d    = ct_q;
        hmac_d  = hmac_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_val) begin
                    work_d  = req_plaintext;
                    tag_d   = MAC_KEY;
                    blk_d   = '0;
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                work_d = work_nx;
                tag_d  = tag_nx;
                if (blk_q == LAST) begin
                    ct_d    = work_nx;
                    hmac_d  = tag_nx ^ seq_bind;
                    blk_d   = '0;
                    state_d = S_RESP;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_rdy) begin
                    seq_d   = seq_q + 32'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            blk_q   <= '0;
            work_q  <= '0;
            tag_q   <= '0;
            ct_q    <= '0;
            hmac_q  <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            blk_q   <= blk_d;
            work_q  <= work_d;
            tag_q   <= tag_d;
            ct_q    <= ct_d;
            hmac_q  <= hmac_d;
        end
    end

    assign req_rdy         = (state_q == S_IDLE);
    assign resp_val        = (state_q == S_RESP);
    assign resp_ciphertext = ct_q;
    assign resp_hmac       = hmac_q;
    assign resp_seq        = seq_q;

endmodule
